// File: rtl/l1_addr_router.sv
// l1_addr_router: host-side address router for the L1 interconnect.
// Decodes the Ibex-style host address against a base/mask region table,
// forms the interconnect target address and tracks in-flight accesses so
// that every accepted access returns exactly one in-order response.
// Optional feature macro: L1_ROUTER_DECERR_EN -- when defined, unmapped
// accesses are granted locally and answered with host_err_o=1; when not
// defined they are routed to DefaultRegion like any mapped access.
module l1_addr_router #(
    parameter int unsigned NumRegions     = 6,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned TgtIdxWidth    = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionBase = '0,
    parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionMask = '1,
    parameter int unsigned DefaultRegion  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   host_req_i,
    output logic                   host_gnt_o,
    input  logic [AddrWidth-1:0]   host_addr_i,
    input  logic                   host_we_i,
    input  logic [DataWidth/8-1:0] host_be_i,
    input  logic [DataWidth-1:0]   host_wdata_i,
    output logic                   host_rvalid_o,
    output logic [DataWidth-1:0]   host_rdata_o,
    output logic                   host_err_o,
    output logic                   net_req_valid_o,
    input  logic                   net_req_ready_i,
    output logic [AddrWidth-1:0]   net_tgt_addr_o,
    output logic                   net_wen_o,
    output logic [DataWidth/8-1:0] net_be_o,
    output logic [DataWidth-1:0]   net_wdata_o,
    input  logic                   net_resp_valid_i,
    output logic                   net_resp_ready_o,
    input  logic [DataWidth-1:0]   net_resp_data_i
);

    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic                   hit_p0;
    logic [TgtIdxWidth-1:0] hit_idx_p0;
    logic [TgtIdxWidth-1:0] tgt_idx_p0;
    logic                   full_p0;
    logic                   req_ok_p0;
    logic                   push_p0;
    logic                   net_pop_p0;
    logic                   pop_p0;
    logic                   head_err_p0;
    logic [CntW-1:0]        count_q;

    logic                   rsp_vld_p1;
    logic                   rsp_err_p1;
    logic [DataWidth-1:0]   rsp_data_p1;

    // ---- stage p0: combinational decode and request handshake ----

    // Region decode: iterate high to low so the lowest matching index wins.
    always_comb begin
        hit_p0     = 1'b0;
        hit_idx_p0 = '0;
        for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
            if ((host_addr_i & RegionMask[i]) == RegionBase[i]) begin
                hit_p0     = 1'b1;
                hit_idx_p0 = TgtIdxWidth'(i);
            end
        end
    end

    assign full_p0   = (count_q == CntMax);
    assign req_ok_p0 = host_req_i & ~full_p0 & ~rst_i;

    // Target address: low host address bits shifted up past the index and word offset.
    assign net_tgt_addr_o = {host_addr_i[AddrWidth-TgtIdxWidth-3:0], tgt_idx_p0, 2'b00};
    assign net_wen_o      = host_we_i;
    assign net_be_o       = host_be_i;
    assign net_wdata_o    = host_wdata_i;

`ifdef L1_ROUTER_DECERR_EN
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [MaxOutstanding-1:0] err_fifo_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tgt_idx_p0      = hit_idx_p0;
    // Unmapped accesses never reach the network; they are granted locally.
    assign net_req_valid_o = req_ok_p0 & hit_p0;
    assign host_gnt_o      = hit_p0 ? (net_req_valid_o & net_req_ready_i) : req_ok_p0;
    assign head_err_p0     = (count_q != '0) & err_fifo_q[rd_ptr_q];

    // Tracking FIFO storage: one is_err bit per accepted access.
    always_ff @(posedge clk_i) begin
        if (push_p0) begin
            err_fifo_q[wr_ptr_q] <= ~hit_p0;
        end
    end

    // FIFO pointers, wrapping modulo MaxOutstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_p0) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end
`else
    // Without local error responses every access goes to the network.
    assign tgt_idx_p0      = hit_p0 ? hit_idx_p0 : TgtIdxWidth'(DefaultRegion);
    assign net_req_valid_o = req_ok_p0;
    assign host_gnt_o      = req_ok_p0 & net_req_ready_i;
    assign head_err_p0     = 1'b0;
`endif

    // An error at the head blocks the network response channel until answered locally.
    assign net_resp_ready_o = ~head_err_p0;
    assign push_p0          = host_gnt_o;
    assign net_pop_p0       = net_resp_valid_i & net_resp_ready_o & (count_q != '0);
    assign pop_p0           = net_pop_p0 | head_err_p0;

    // Outstanding-access counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (push_p0 && !pop_p0) begin
            count_q <= count_q + 1'b1;
        end else if (!push_p0 && pop_p0) begin
            count_q <= count_q - 1'b1;
        end
    end

    // ---- stage p1: registered host response ----

    // Register one response per popped entry; a response with an empty FIFO is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_vld_p1  <= 1'b0;
            rsp_err_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            rsp_vld_p1 <= pop_p0;
            if (pop_p0) begin
                rsp_err_p1  <= head_err_p0;
                rsp_data_p1 <= head_err_p0 ? '0 : net_resp_data_i;
            end
        end
    end

    assign host_rvalid_o = rsp_vld_p1;
    assign host_rdata_o  = rsp_data_p1;
    assign host_err_o    = rsp_err_p1;

endmodule

// File: tb/tb_l1_addr_router.sv
// tb_l1_addr_router: randomized plus directed bench for l1_addr_router,
// checked against a queue-based behavioural model of the router.
module tb_l1_addr_router;

    localparam int NREG  = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TIW   = 3;
    localparam int MAXO  = 4;
    localparam int DEFREG = 2;
    localparam logic [NREG-1:0][AW-1:0] BASE =
        {32'h0010_0000, 32'h1000_0000, 32'h0020_0000, 32'h0010_0000};
    localparam logic [NREG-1:0][AW-1:0] MASK =
        {32'hFFF0_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
`ifdef L1_ROUTER_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            host_req_i = 1'b0;
    logic            host_gnt_o;
    logic [AW-1:0]   host_addr_i = '0;
    logic            host_we_i = 1'b0;
    logic [DW/8-1:0] host_be_i = '0;
    logic [DW-1:0]   host_wdata_i = '0;
    logic            host_rvalid_o;
    logic [DW-1:0]   host_rdata_o;
    logic            host_err_o;
    logic            net_req_valid_o;
    logic            net_req_ready_i = 1'b0;
    logic [AW-1:0]   net_tgt_addr_o;
    logic            net_wen_o;
    logic [DW/8-1:0] net_be_o;
    logic [DW-1:0]   net_wdata_o;
    logic            net_resp_valid_i = 1'b0;
    logic            net_resp_ready_o;
    logic [DW-1:0]   net_resp_data_i = '0;

    int n_vec = 0;
    int n_miscmp = 0;

    // Reference model state
    bit          pend[$];      // in-order accepted accesses, 1 = local error
    int          netcnt = 0;   // mapped accesses awaiting a network response
    bit          exp_rv = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;

    l1_addr_router #(
        .NumRegions(NREG), .AddrWidth(AW), .DataWidth(DW), .TgtIdxWidth(TIW),
        .MaxOutstanding(MAXO), .RegionBase(BASE), .RegionMask(MASK),
        .DefaultRegion(DEFREG)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
        .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .net_req_valid_o(net_req_valid_o), .net_req_ready_i(net_req_ready_i),
        .net_tgt_addr_o(net_tgt_addr_o), .net_wen_o(net_wen_o), .net_be_o(net_be_o),
        .net_wdata_o(net_wdata_o), .net_resp_valid_i(net_resp_valid_i),
        .net_resp_ready_o(net_resp_ready_o), .net_resp_data_i(net_resp_data_i)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First matching region in ascending order.
    function automatic void decode(input logic [31:0] a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NREG; i++) begin
            if (!hit && ((a & MASK[i]) == BASE[i])) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {16'h0010, r[15:0]};
            1: return {16'h0011, r[15:0]};
            2: return {16'h0020, r[15:0]};
            3: return {4'h1, r[27:0]};
            4: return {4'h4, r[27:0]};
            default: return r;
        endcase
    endfunction

    // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        bit hit, mapped, full, nv, gnt, herr, nrv, nerr;
        int idx, ridx;
        logic [31:0] ndata, etgt;
        @(negedge clk_i);
        if (rst_i) begin
            chk("rst_gnt", host_gnt_o, 0);
            chk("rst_req_valid", net_req_valid_o, 0);
            chk("rst_resp_ready", net_resp_ready_o, 1);
            chk("rst_rvalid", host_rvalid_o, 0);
            chk("rst_err", host_err_o, 0);
            chk("rst_rdata", host_rdata_o, 0);
            pend.delete();
            netcnt = 0;
            exp_rv = 1'b0;
            exp_err = 1'b0;
            exp_rdata = '0;
        end else begin
            decode(host_addr_i, hit, idx);
            mapped = hit || !DECERR;
            ridx = hit ? idx : DEFREG;
            full = (pend.size() == MAXO);
            nv = host_req_i && !full && mapped;
            gnt = mapped ? (nv && net_req_ready_i) : (host_req_i && !full);
            herr = (pend.size() > 0) && pend[0];
            etgt = 32'((host_addr_i << (TIW + 2)) | (32'(ridx) << 2));
            chk("req_valid", net_req_valid_o, nv);
            chk("gnt", host_gnt_o, gnt);
            chk("resp_ready", net_resp_ready_o, !herr);
            chk("rvalid", host_rvalid_o, exp_rv);
            if (exp_rv) begin
                chk("rdata", host_rdata_o, exp_rdata);
                chk("err", host_err_o, exp_err);
            end
            if (nv) begin
                chk("tgt_addr", net_tgt_addr_o, etgt);
                chk("wen", net_wen_o, host_we_i);
                chk("be", net_be_o, host_be_i);
                chk("wdata", net_wdata_o, host_wdata_i);
            end
            nrv = 1'b0;
            nerr = 1'b0;
            ndata = '0;
            if (herr) begin
                void'(pend.pop_front());
                nrv = 1'b1;
                nerr = 1'b1;
            end else if (net_resp_valid_i && pend.size() > 0) begin
                void'(pend.pop_front());
                netcnt--;
                nrv = 1'b1;
                ndata = net_resp_data_i;
            end
            if (gnt) begin
                pend.push_back(!mapped);
                if (mapped) netcnt++;
            end
            exp_rv = nrv;
            if (nrv) begin
                exp_rdata = ndata;
                exp_err = nerr;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        host_req_i = 1'b0;
        while (pend.size() > 0 && n < 50) begin
            net_resp_valid_i = (netcnt > 0);
            net_resp_data_i = $urandom;
            step();
            n++;
        end
        net_resp_valid_i = 1'b0;
        step();
        chk("drain_done", pend.size(), 0);
    endtask

    initial begin
        #2 rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();

        // Single mapped read, same-cycle grant, response one cycle later
        host_req_i = 1'b1; host_addr_i = 32'h0010_0040; host_we_i = 1'b0;
        host_be_i = 4'hF; net_req_ready_i = 1'b1;
        #1;
        chk("rd_gnt", host_gnt_o, 1);
        chk("rd_tgt", net_tgt_addr_o, 32'h0200_0800);
        step();
        host_req_i = 1'b0; net_resp_valid_i = 1'b1; net_resp_data_i = 32'hCAFE_F00D;
        step();
        net_resp_valid_i = 1'b0;
        #1;
        chk("rd_rvalid", host_rvalid_o, 1);
        chk("rd_rdata", host_rdata_o, 32'hCAFE_F00D);
        chk("rd_err", host_err_o, 0);
        step();
        #1;
        chk("rd_rvalid_1cyc", host_rvalid_o, 0);
        step();

        // Five back-to-back reads with responses withheld
        for (int k = 0; k < 5; k++) begin
            host_req_i = 1'b1; host_addr_i = 32'h0020_0000 + 32'(4 * k);
            #1;
            chk("b2b_gnt", host_gnt_o, (k < MAXO) ? 1 : 0);
            step();
        end
        net_resp_valid_i = 1'b1; net_resp_data_i = 32'h0000_0A01;
        #1;
        chk("full_resp_gnt", host_gnt_o, 0);
        step();
        net_resp_data_i = 32'h0000_0A02;
        #1;
        chk("pushpop_gnt", host_gnt_o, 1);
        step();
        net_resp_valid_i = 1'b0;
        #1;
        chk("after_pushpop_gnt", host_gnt_o, 1);
        step();
        drain();

        // Mapped / unmapped / mapped sequence
        host_req_i = 1'b1; host_addr_i = 32'h0010_0004;
        step();
        host_addr_i = 32'h4000_0000;
        #1;
`ifdef L1_ROUTER_DECERR_EN
        chk("unm_req_valid", net_req_valid_o, 0);
        chk("unm_gnt", host_gnt_o, 1);
`else
        chk("dflt_req_valid", net_req_valid_o, 1);
        chk("dflt_tgt", net_tgt_addr_o, 32'h0000_0008);
`endif
        step();
        host_addr_i = 32'h0020_0008;
        step();
        host_req_i = 1'b0; net_resp_valid_i = 1'b1; net_resp_data_i = 32'h1111_1111;
        step();
        net_resp_data_i = 32'h2222_2222;
        #1;
        chk("seq_first_rdata", host_rdata_o, 32'h1111_1111);
`ifdef L1_ROUTER_DECERR_EN
        chk("err_head_ready", net_resp_ready_o, 0);
        step();
        #1;
        chk("err_rvalid", host_rvalid_o, 1);
        chk("err_flag", host_err_o, 1);
        chk("err_rdata", host_rdata_o, 0);
`endif
        step();
        drain();

        // Reset with three outstanding, then a stale response
        host_req_i = 1'b1; host_addr_i = 32'h0010_0100; net_req_ready_i = 1'b1;
        step();
        step();
        step();
        host_req_i = 1'b0;
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        net_resp_valid_i = 1'b1; net_resp_data_i = 32'hDEAD_BEEF;
        #1;
        chk("stale_ready", net_resp_ready_o, 1);
        step();
        net_resp_valid_i = 1'b0;
        #1;
        chk("stale_no_rvalid", host_rvalid_o, 0);
        step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            host_req_i = ($urandom_range(0, 3) != 0);
            host_addr_i = pick_addr();
            host_we_i = $urandom_range(0, 1);
            host_be_i = 4'($urandom);
            host_wdata_i = $urandom;
            net_req_ready_i = ($urandom_range(0, 3) != 0);
            net_resp_valid_i = (netcnt > 0) && ($urandom_range(0, 1) == 1);
            net_resp_data_i = $urandom;
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
